// File: rtl/avalon_mst_responder.sv
// On-chip responder for the avalon_rd_wr read/write master control and user ports.
// Two independent engines stream 128-bit words through 8-deep FIFOs to/from a dual-port RAM.
module avalon_mst_responder #(
  parameter int XAW     = 32,
  parameter int XDW     = 128,
  parameter int MEM_AW  = 8,
  parameter int FIFO_AW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           read_control_fixed_location,
  input  logic [XAW-1:0] read_control_read_base,
  input  logic [XAW-1:0] read_control_read_length,
  input  logic           read_control_go,
  output logic           read_control_done,
  input  logic           read_user_read_buffer,
  output logic [XDW-1:0] read_user_buffer_output_data,
  output logic           read_user_data_available,
  input  logic           write_control_fixed_location,
  input  logic [XAW-1:0] write_control_write_base,
  input  logic [XAW-1:0] write_control_write_length,
  input  logic           write_control_go,
  output logic           write_control_done,
  input  logic           write_user_write_buffer,
  input  logic [XDW-1:0] write_user_buffer_input_data,
  output logic           write_user_buffer_full
);

  localparam int CW    = XAW - 4;
  localparam int FCW   = FIFO_AW + 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [MEM_AW-1:0]  ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FCW-1:0]     FCNT_ZERO = {FCW{1'b0}};
  localparam logic [FCW-1:0]     FCNT_ONE  = {{(FCW-1){1'b0}}, 1'b1};
  localparam logic [FCW-1:0]     FDEPTH    = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_FETCH = 2'd1, RD_DRAIN = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACCEPT = 2'd1, WR_FLUSH = 2'd2} wr_state_t;

  logic [XDW-1:0] mem_r [2**MEM_AW];
  logic [XDW-1:0] ram_q_r;

  // read engine state
  rd_state_t          rd_state_r, rd_nxt_s;
  logic [MEM_AW-1:0]  rd_addr_r;
  logic [CW-1:0]      rd_cnt_r;
  logic               rd_fixed_r;
  logic               land_v_r;
  logic [XDW-1:0]     rf_mem_r [DEPTH];
  logic [FIFO_AW-1:0] rf_wp_r, rf_rp_r;
  logic [FCW-1:0]     rf_cnt_r, rf_cnt_nxt_s;
  logic [FCW:0]       rd_occ_s;
  logic               rd_done_r, rd_avail_r;
  logic               rd_go_s, rd_issue_s, rf_push_s, rf_pop_s;

  // write engine state
  wr_state_t          wr_state_r, wr_nxt_s;
  logic [MEM_AW-1:0]  wr_addr_r;
  logic [CW-1:0]      wr_acc_r, wr_acc_nxt_s, wr_cnt_r;
  logic               wr_fixed_r;
  logic [XDW-1:0]     wf_mem_r [DEPTH];
  logic [FIFO_AW-1:0] wf_wp_r, wf_rp_r;
  logic [FCW-1:0]     wf_cnt_r, wf_cnt_nxt_s;
  logic               wr_done_r, wr_full_r;
  logic               wr_go_s, wf_push_s, wf_pop_s;

  logic unused_s;

  assign unused_s = ^{read_control_read_base[XAW-1:MEM_AW+4], read_control_read_base[3:0],
                      read_control_read_length[3:0], write_control_write_base[XAW-1:MEM_AW+4],
                      write_control_write_base[3:0], write_control_write_length[3:0]};

  assign rd_go_s   = read_control_go && (rd_state_r == RD_IDLE) &&
                     (read_control_read_length[XAW-1:4] != CNT_ZERO);
  assign rd_occ_s  = {1'b0, rf_cnt_r} + {{FCW{1'b0}}, land_v_r};
  assign rd_issue_s = (rd_state_r == RD_FETCH) && (rd_occ_s < {1'b0, FDEPTH});
  assign rf_push_s = land_v_r;
  assign rf_pop_s  = read_user_read_buffer && (rf_cnt_r != FCNT_ZERO);

  assign wr_go_s   = write_control_go && (wr_state_r == WR_IDLE) &&
                     (write_control_write_length[XAW-1:4] != CNT_ZERO);
  assign wf_push_s = write_user_write_buffer && !wr_full_r && (wr_acc_r != CNT_ZERO);
  assign wf_pop_s  = (wf_cnt_r != FCNT_ZERO) && (wr_cnt_r != CNT_ZERO);

  assign read_control_done            = rd_done_r;
  assign read_user_data_available     = rd_avail_r;
  assign read_user_buffer_output_data = rf_mem_r[rf_rp_r];
  assign write_control_done           = wr_done_r;
  assign write_user_buffer_full       = wr_full_r;

  // Dual-port RAM: no reset so contents survive; same-address read returns old data.
  always_ff @(posedge clk) begin
    if (wf_pop_s) mem_r[wr_addr_r] <= wf_mem_r[wf_rp_r];
    ram_q_r <= mem_r[rd_addr_r];
  end

  // Read FSM next state
  always_comb begin
    rd_nxt_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE:  if (rd_go_s) rd_nxt_s = RD_FETCH; else rd_nxt_s = RD_IDLE;
      RD_FETCH: if (rd_issue_s && (rd_cnt_r == CNT_ONE)) rd_nxt_s = RD_DRAIN; else rd_nxt_s = RD_FETCH;
      RD_DRAIN: if (!land_v_r && (rf_cnt_r == FCNT_ZERO)) rd_nxt_s = RD_IDLE; else rd_nxt_s = RD_DRAIN;
      default:  rd_nxt_s = RD_IDLE;
    endcase
  end

  // Read FIFO occupancy after this cycle's push/pop
  always_comb begin
    rf_cnt_nxt_s = rf_cnt_r;
    case ({rf_push_s, rf_pop_s})
      2'b10:   rf_cnt_nxt_s = rf_cnt_r + FCNT_ONE;
      2'b01:   rf_cnt_nxt_s = rf_cnt_r - FCNT_ONE;
      default: rf_cnt_nxt_s = rf_cnt_r;
    endcase
  end

  // Read engine registers and read FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_r <= RD_IDLE;
      rd_addr_r  <= {MEM_AW{1'b0}};
      rd_cnt_r   <= CNT_ZERO;
      rd_fixed_r <= 1'b0;
      land_v_r   <= 1'b0;
      rf_wp_r    <= {FIFO_AW{1'b0}};
      rf_rp_r    <= {FIFO_AW{1'b0}};
      rf_cnt_r   <= FCNT_ZERO;
      rd_done_r  <= 1'b1;
      rd_avail_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rf_mem_r[i] <= {XDW{1'b0}};
    end else begin
      rd_state_r <= rd_nxt_s;
      rd_done_r  <= (rd_nxt_s == RD_IDLE);
      if (rd_go_s) begin
        rd_addr_r  <= read_control_read_base[MEM_AW+3:4];
        rd_cnt_r   <= read_control_read_length[XAW-1:4];
        rd_fixed_r <= read_control_fixed_location;
      end else if (rd_issue_s) begin
        if (!rd_fixed_r) rd_addr_r <= rd_addr_r + ADDR_ONE;
        rd_cnt_r <= rd_cnt_r - CNT_ONE;
      end
      land_v_r <= rd_issue_s;
      if (rf_push_s) begin
        rf_mem_r[rf_wp_r] <= ram_q_r;
        rf_wp_r <= rf_wp_r + PTR_ONE;
      end
      if (rf_pop_s) rf_rp_r <= rf_rp_r + PTR_ONE;
      rf_cnt_r   <= rf_cnt_nxt_s;
      rd_avail_r <= (rf_cnt_nxt_s != FCNT_ZERO);
    end
  end

  // Write FSM next state
  always_comb begin
    wr_nxt_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE:   if (wr_go_s) wr_nxt_s = WR_ACCEPT; else wr_nxt_s = WR_IDLE;
      WR_ACCEPT: if (wr_acc_r == CNT_ZERO) wr_nxt_s = WR_FLUSH; else wr_nxt_s = WR_ACCEPT;
      WR_FLUSH:  if (wr_cnt_r == CNT_ZERO) wr_nxt_s = WR_IDLE; else wr_nxt_s = WR_FLUSH;
      default:   wr_nxt_s = WR_IDLE;
    endcase
  end

  // Accept count and write FIFO occupancy; both feed the registered full flag
  always_comb begin
    wr_acc_nxt_s = wr_acc_r;
    wf_cnt_nxt_s = wf_cnt_r;
    if (wr_go_s) wr_acc_nxt_s = write_control_write_length[XAW-1:4];
    else if (wf_push_s) wr_acc_nxt_s = wr_acc_r - CNT_ONE;
    else wr_acc_nxt_s = wr_acc_r;
    case ({wf_push_s, wf_pop_s})
      2'b10:   wf_cnt_nxt_s = wf_cnt_r + FCNT_ONE;
      2'b01:   wf_cnt_nxt_s = wf_cnt_r - FCNT_ONE;
      default: wf_cnt_nxt_s = wf_cnt_r;
    endcase
  end

  // Write engine registers and write FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_r <= WR_IDLE;
      wr_addr_r  <= {MEM_AW{1'b0}};
      wr_acc_r   <= CNT_ZERO;
      wr_cnt_r   <= CNT_ZERO;
      wr_fixed_r <= 1'b0;
      wf_wp_r    <= {FIFO_AW{1'b0}};
      wf_rp_r    <= {FIFO_AW{1'b0}};
      wf_cnt_r   <= FCNT_ZERO;
      wr_done_r  <= 1'b1;
      wr_full_r  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) wf_mem_r[i] <= {XDW{1'b0}};
    end else begin
      wr_state_r <= wr_nxt_s;
      wr_done_r  <= (wr_nxt_s == WR_IDLE);
      wr_acc_r   <= wr_acc_nxt_s;
      wf_cnt_r   <= wf_cnt_nxt_s;
      wr_full_r  <= (wf_cnt_nxt_s == FDEPTH) || (wr_acc_nxt_s == CNT_ZERO);
      if (wr_go_s) begin
        wr_addr_r  <= write_control_write_base[MEM_AW+3:4];
        wr_cnt_r   <= write_control_write_length[XAW-1:4];
        wr_fixed_r <= write_control_fixed_location;
      end else if (wf_pop_s) begin
        if (!wr_fixed_r) wr_addr_r <= wr_addr_r + ADDR_ONE;
        wr_cnt_r <= wr_cnt_r - CNT_ONE;
      end
      if (wf_push_s) begin
        wf_mem_r[wf_wp_r] <= write_user_buffer_input_data;
        wf_wp_r <= wf_wp_r + PTR_ONE;
      end
      if (wf_pop_s) wf_rp_r <= wf_rp_r + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_avalon_mst_responder.sv
// Scoreboard bench for avalon_mst_responder: stimulus queues expected read words,
// a negedge monitor pops and compares each word the DUT hands out.
module tb_avalon_mst_responder;

  logic         clk;
  logic         rst;
  logic         read_control_fixed_location;
  logic [31:0]  read_control_read_base;
  logic [31:0]  read_control_read_length;
  logic         read_control_go;
  logic         read_control_done;
  logic         read_user_read_buffer;
  logic [127:0] read_user_buffer_output_data;
  logic         read_user_data_available;
  logic         write_control_fixed_location;
  logic [31:0]  write_control_write_base;
  logic [31:0]  write_control_write_length;
  logic         write_control_go;
  logic         write_control_done;
  logic         write_user_write_buffer;
  logic [127:0] write_user_buffer_input_data;
  logic         write_user_buffer_full;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] sb_q[$];

  avalon_mst_responder dut (
    .clk                          (clk),
    .rst                          (rst),
    .read_control_fixed_location  (read_control_fixed_location),
    .read_control_read_base       (read_control_read_base),
    .read_control_read_length     (read_control_read_length),
    .read_control_go              (read_control_go),
    .read_control_done            (read_control_done),
    .read_user_read_buffer        (read_user_read_buffer),
    .read_user_buffer_output_data (read_user_buffer_output_data),
    .read_user_data_available     (read_user_data_available),
    .write_control_fixed_location (write_control_fixed_location),
    .write_control_write_base     (write_control_write_base),
    .write_control_write_length   (write_control_write_length),
    .write_control_go             (write_control_go),
    .write_control_done           (write_control_done),
    .write_user_write_buffer      (write_user_write_buffer),
    .write_user_buffer_input_data (write_user_buffer_input_data),
    .write_user_buffer_full       (write_user_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: every word popped by the bench is checked against the scoreboard
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst && read_user_read_buffer && read_user_data_available) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data_unexpected actual=%0h expected=none", read_user_buffer_output_data);
      end else begin
        e = sb_q.pop_front();
        chk("rd_data", read_user_buffer_output_data, e);
      end
    end
  end

  task automatic do_write(input logic [31:0] base, input logic [31:0] len, input logic fixed,
                          input int n_push, input logic [127:0] v0, output int lat);
    write_control_write_base     = base;
    write_control_write_length   = len;
    write_control_fixed_location = fixed;
    write_control_go = 1'b1;
    tick();
    write_control_go = 1'b0;
    for (int i = 0; i < n_push; i++) begin
      write_user_write_buffer      = 1'b1;
      write_user_buffer_input_data = v0 + 128'(i);
      tick();
    end
    write_user_write_buffer = 1'b0;
    lat = 0;
    while (!write_control_done && lat < 200) begin
      tick();
      lat++;
    end
    chk("wr_done", {127'd0, write_control_done}, 128'd1);
    chk("wr_full_idle", {127'd0, write_user_buffer_full}, 128'd1);
  endtask

  task automatic do_read(input logic [31:0] base, input logic [31:0] len, input logic fixed);
    int c;
    read_control_read_base      = base;
    read_control_read_length    = len;
    read_control_fixed_location = fixed;
    read_user_read_buffer = 1'b1;
    read_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    c = 0;
    while (!read_control_done && c < 400) begin
      tick();
      c++;
    end
    read_user_read_buffer = 1'b0;
    chk("rd_done", {127'd0, read_control_done}, 128'd1);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_done"}, {127'd0, read_control_done}, 128'd1);
    chk({tag, "_avail"}, {127'd0, read_user_data_available}, 128'd0);
    chk({tag, "_rd_data"}, read_user_buffer_output_data, 128'd0);
    chk({tag, "_wr_done"}, {127'd0, write_control_done}, 128'd1);
    chk({tag, "_full"}, {127'd0, write_user_buffer_full}, 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c;
    rst = 1'b0;
    read_control_fixed_location = 1'b0;
    read_control_read_base = 32'd0;
    read_control_read_length = 32'd0;
    read_control_go = 1'b0;
    read_user_read_buffer = 1'b0;
    write_control_fixed_location = 1'b0;
    write_control_write_base = 32'd0;
    write_control_write_length = 32'd0;
    write_control_go = 1'b0;
    write_user_write_buffer = 1'b0;
    write_user_buffer_input_data = 128'd0;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b1;
    tick();

    // zero-length go is ignored on both engines
    read_control_read_length = 32'd0;
    read_control_go = 1'b1;
    write_control_write_length = 32'h0000000F;
    write_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    write_control_go = 1'b0;
    chk("len0_rd_done", {127'd0, read_control_done}, 128'd1);
    chk("len0_wr_done", {127'd0, write_control_done}, 128'd1);
    chk("len0_full", {127'd0, write_user_buffer_full}, 128'd1);
    tick();
    chk("len0_rd_done2", {127'd0, read_control_done}, 128'd1);

    // write 64 words 0..63 at 0x40; done two edges after the last push
    do_write(32'h40, 32'd1024, 1'b0, 64, 128'd0, lat);
    chk("wr_done_lat", 128'(lat), 128'd2);

    // read them back with read_buffer held: first data 2 edges after go
    for (int i = 0; i < 64; i++) sb_q.push_back(128'(i));
    read_control_read_base = 32'h40;
    read_control_read_length = 32'd1024;
    read_control_fixed_location = 1'b0;
    read_user_read_buffer = 1'b1;
    read_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    chk("rd_go_done_low", {127'd0, read_control_done}, 128'd0);
    chk("rd_avail_n0", {127'd0, read_user_data_available}, 128'd0);
    tick();
    chk("rd_avail_n1", {127'd0, read_user_data_available}, 128'd0);
    tick();
    chk("rd_avail_n2", {127'd0, read_user_data_available}, 128'd1);
    c = 2;
    while (!read_control_done && c < 300) begin
      tick();
      c++;
    end
    read_user_read_buffer = 1'b0;
    chk("rd_done_lat", 128'(c), 128'd67);
    chk("rd_sb_empty", 128'(sb_q.size()), 128'd0);

    // backpressure: 16 words, no pops; a second go while busy is ignored
    for (int i = 0; i < 16; i++) sb_q.push_back(128'(i));
    read_control_read_base = 32'h40;
    read_control_read_length = 32'd256;
    read_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    repeat (4) tick();
    read_control_read_base = 32'h200;
    read_control_read_length = 32'd16;
    read_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    repeat (20) tick();
    chk("bp_avail", {127'd0, read_user_data_available}, 128'd1);
    chk("bp_done_low", {127'd0, read_control_done}, 128'd0);
    chk("bp_no_pops", 128'(sb_q.size()), 128'd16);
    read_user_read_buffer = 1'b1;
    c = 0;
    while (!read_control_done && c < 300) begin
      tick();
      c++;
    end
    read_user_read_buffer = 1'b0;
    chk("bp_done", {127'd0, read_control_done}, 128'd1);
    chk("bp_sb_empty", 128'(sb_q.size()), 128'd0);

    // pushes beyond a 4-word write are dropped
    do_write(32'h200, 32'd128, 1'b0, 8, 128'h50, lat);
    do_write(32'h200, 32'd64, 1'b0, 6, 128'h100, lat);
    for (int i = 0; i < 4; i++) sb_q.push_back(128'h100 + 128'(i));
    for (int i = 4; i < 8; i++) sb_q.push_back(128'h50 + 128'(i));
    do_read(32'h200, 32'd128, 1'b0);

    // fixed location write and read
    do_write(32'h100, 32'd64, 1'b1, 4, 128'hA, lat);
    for (int i = 0; i < 3; i++) sb_q.push_back(128'hD);
    do_read(32'h100, 32'd48, 1'b1);
    sb_q.push_back(128'hD);
    do_read(32'h100, 32'd16, 1'b0);

    // address wrap: 0xFF then 0x00
    do_write(32'hFF0, 32'd32, 1'b0, 2, 128'h77, lat);
    sb_q.push_back(128'h77);
    sb_q.push_back(128'h78);
    do_read(32'hFF0, 32'd32, 1'b0);
    sb_q.push_back(128'h78);
    do_read(32'h0, 32'd16, 1'b0);

    // reset in the middle of a read and a write
    read_control_read_base = 32'h40;
    read_control_read_length = 32'd256;
    read_control_go = 1'b1;
    write_control_write_base = 32'h300;
    write_control_write_length = 32'd1024;
    write_control_fixed_location = 1'b0;
    write_control_go = 1'b1;
    tick();
    read_control_go = 1'b0;
    write_control_go = 1'b0;
    write_user_write_buffer = 1'b1;
    write_user_buffer_input_data = 128'h99;
    tick();
    tick();
    write_user_write_buffer = 1'b0;
    tick();
    chk("mid_busy", {127'd0, read_control_done}, 128'd0);
    rst = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b1;
    tick();
    chk_reset_vals("postrst");
    sb_q.push_back(128'hD);
    do_read(32'h100, 32'd16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
